// File: rtl/seq_addsub_if.sv
// Operand/result handshake bundle for seq_addsub: request side (A, B, sub, cin)
// and response side (S and flags), each with its own valid/ready pair.
interface seq_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             cout;
  logic             ovfl;
  logic             zero;

  modport master (
    output in_valid, A, B, sub, cin, out_ready,
    input  in_ready, out_valid, S, cout, ovfl, zero
  );

  modport slave (
    input  in_valid, A, B, sub, cin, out_ready,
    output in_ready, out_valid, S, cout, ovfl, zero
  );
endinterface

// File: rtl/seq_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor: one CHUNK-bit carry slice per clock,
// so the combinational carry path never exceeds CHUNK bits.
module seq_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  seq_addsub_if.slave  bus
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   s_q, s_next;
  logic               cout_q, ovfl_q, zero_q;
  logic               carry;
  logic [IDX_W-1:0]   idx;
  logic [CHUNK-1:0]   a_sl, b_sl;
  logic [CHUNK:0]     sum_sl;
  logic               ovfl_next;
  logic               accept, step, last;

  function automatic logic [CHUNK:0] slice_add(input logic [CHUNK-1:0] a,
                                                input logic [CHUNK-1:0] b,
                                                input logic             c);
    return {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, c};
  endfunction

  assign accept = (state == IDLE) && bus.in_valid && !clr;
  assign step   = (state == RUN) && !clr;
  assign last   = (idx == LAST);

  always_comb begin
    a_sl   = a_q[idx*CHUNK +: CHUNK];
    b_sl   = b_q[idx*CHUNK +: CHUNK];
    sum_sl = slice_add(a_sl, b_sl, carry);
    s_next = s_q;
    s_next[idx*CHUNK +: CHUNK] = sum_sl[CHUNK-1:0];
    // a^b^s at the MSB recovers the carry into it; XOR with carry out gives overflow
    ovfl_next = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ s_next[WIDTH-1] ^ sum_sl[CHUNK];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = RUN;
      end
      RUN:  if (last) state_nxt = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  // Operands are only read while RUN, after a capture, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= bus.A;
      b_q <= bus.B ^ {WIDTH{bus.sub}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      cout_q <= 1'b0;
      ovfl_q <= 1'b0;
      zero_q <= 1'b0;
      carry  <= 1'b0;
      idx    <= '0;
    end else if (accept) begin
      carry <= bus.cin ^ bus.sub;
      idx   <= '0;
    end else if (step) begin
      s_q   <= s_next;
      carry <= sum_sl[CHUNK];
      if (last) begin
        idx    <= '0;
        cout_q <= sum_sl[CHUNK];
        ovfl_q <= ovfl_next;
        zero_q <= (s_next == '0);
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  assign bus.S    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovfl = ovfl_q;
  assign bus.zero = zero_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Directed bench for seq_addsub with CHUNK=4 (4 slices) and CHUNK=16 (single slice).
module tb_seq_addsub;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_addsub_if #(.WIDTH(16)) if4 ();
  seq_addsub_if #(.WIDTH(16)) if16 ();

  seq_addsub #(.WIDTH(16), .CHUNK(4))  dut4  (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(if4.slave));
  seq_addsub #(.WIDTH(16), .CHUNK(16)) dut16 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(if16.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] pack(input logic [15:0] s, input logic c, input logic o, input logic z);
    return {s, c, o, z};
  endfunction

  // Independent reference: full-width sum, overflow from operand/result signs.
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic s, input logic c);
    logic [15:0] bm;
    logic [16:0] full;
    logic        o;
    bm   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bm} + {16'd0, c ^ s};
    o    = (a[15] == bm[15]) && (full[15] != a[15]);
    return {full[15:0], full[16], o, (full[15:0] == 16'd0)};
  endfunction

  function automatic logic [18:0] res4();
    return {if4.S, if4.cout, if4.ovfl, if4.zero};
  endfunction

  function automatic logic [18:0] res16();
    return {if16.S, if16.cout, if16.ovfl, if16.zero};
  endfunction

  task automatic run_op(input bit big, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic c, output int lat, output logic [18:0] res);
    @(negedge clk);
    if (big) begin
      if16.A = a; if16.B = b; if16.sub = s; if16.cin = c; if16.in_valid = 1'b1;
    end else begin
      if4.A = a; if4.B = b; if4.sub = s; if4.cin = c; if4.in_valid = 1'b1;
    end
    @(posedge clk); #1;
    if4.in_valid  = 1'b0;
    if16.in_valid = 1'b0;
    lat = 0;
    while (!(big ? if16.out_valid : if4.out_valid) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = big ? res16() : res4();
  endtask

  task automatic release_out();
    @(negedge clk);
    if4.out_ready  = 1'b1;
    if16.out_ready = 1'b1;
    @(posedge clk); #1;
    if4.out_ready  = 1'b0;
    if16.out_ready = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [18:0] res;
    logic [18:0] held;
    logic        seen;
    logic [15:0] ra, rb;
    logic        rs, rc;

    rst_n = 1'b0; clr = 1'b0;
    if4.in_valid = 0; if4.A = 0; if4.B = 0; if4.sub = 0; if4.cin = 0; if4.out_ready = 0;
    if16.in_valid = 0; if16.A = 0; if16.B = 0; if16.sub = 0; if16.cin = 0; if16.out_ready = 0;

    #12;
    check("rst_hs", {30'd0, if4.in_ready, if4.out_valid}, 32'b10);
    check("rst_res", 32'(res4()), 32'(pack(16'h0000, 0, 0, 0)));
    @(negedge clk); rst_n = 1'b1;

    // Signed overflow on add, latency N=4
    run_op(0, 16'h7FFF, 16'h0001, 0, 0, lat, res);
    check("ovf_lat", 32'(lat), 32'd4);
    check("ovf_res", 32'(res), 32'(pack(16'h8000, 0, 1, 0)));
    check("done_hs", {30'd0, if4.in_ready, if4.out_valid}, 32'b01);
    release_out();
    check("idle_hs", {30'd0, if4.in_ready, if4.out_valid}, 32'b10);

    run_op(0, 16'h1234, 16'h1234, 1, 0, lat, res);
    check("sub_zero", 32'(res), 32'(pack(16'h0000, 1, 0, 1)));
    release_out();

    run_op(0, 16'hFFFF, 16'h0001, 0, 1, lat, res);
    check("add_cin", 32'(res), 32'(pack(16'h0001, 1, 0, 0)));
    release_out();

    run_op(0, 16'h8000, 16'h0001, 1, 0, lat, res);
    check("sub_ovf", 32'(res), 32'(pack(16'h7FFF, 1, 1, 0)));
    release_out();

    run_op(0, 16'h1000, 16'h2000, 1, 1, lat, res);
    check("sub_borrow", 32'(res), 32'(pack(16'hEFFF, 0, 0, 0)));
    release_out();

    // Backpressure: result held while inputs wiggle
    run_op(0, 16'h0100, 16'h0023, 0, 0, lat, res);
    check("bp_first", 32'(res), 32'(pack(16'h0123, 0, 0, 0)));
    held = res;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if4.in_valid = i[0];
      if4.A = 16'hA5A5 ^ 16'(i);
      if4.B = 16'h5A5A + 16'(i);
      if4.sub = i[1];
      @(posedge clk); #1;
      check("bp_hold", 32'(res4()), 32'(held));
      check("bp_hs", {30'd0, if4.in_ready, if4.out_valid}, 32'b01);
    end
    @(negedge clk);
    if4.in_valid = 1'b0; if4.out_ready = 1'b1;
    @(posedge clk); #1;
    if4.out_ready = 1'b0;
    check("bp_idle", {30'd0, if4.in_ready, if4.out_valid}, 32'b10);
    run_op(0, 16'h0005, 16'h0006, 0, 0, lat, res);
    check("bp_next_lat", 32'(lat), 32'd4);
    check("bp_next", 32'(res), 32'(pack(16'h000B, 0, 0, 0)));
    release_out();

    // clr in the second RUN cycle
    @(negedge clk);
    if4.A = 16'h1111; if4.B = 16'h2222; if4.sub = 0; if4.cin = 0; if4.in_valid = 1'b1;
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
    check("clr_run", {30'd0, if4.in_ready, if4.out_valid}, 32'b00);
    @(posedge clk); #1;
    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("clr_idle", {30'd0, if4.in_ready, if4.out_valid}, 32'b10);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      seen = seen | if4.out_valid;
    end
    check("clr_noval", {31'd0, seen}, 32'd0);

    // clr with in_valid in IDLE blocks acceptance
    @(negedge clk); clr = 1'b1; if4.in_valid = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; if4.in_valid = 1'b0;
    check("clr_noacc", {31'd0, if4.in_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      seen = seen | if4.out_valid | ~if4.in_ready;
    end
    check("clr_noacc_q", {31'd0, seen}, 32'd0);

    // Asynchronous reset mid-RUN
    @(negedge clk);
    if4.A = 16'hFFFF; if4.B = 16'h0001; if4.sub = 0; if4.cin = 0; if4.in_valid = 1'b1;
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_hs", {30'd0, if4.in_ready, if4.out_valid}, 32'b10);
    check("arst_res", 32'(res4()), 32'(pack(16'h0000, 0, 0, 0)));
    @(negedge clk); rst_n = 1'b1;
    run_op(0, 16'h0003, 16'h0004, 0, 0, lat, res);
    check("arst_lat", 32'(lat), 32'd4);
    check("arst_add", 32'(res), 32'(pack(16'h0007, 0, 0, 0)));
    release_out();

    // Single-slice configuration
    run_op(1, 16'h7FFF, 16'h0001, 0, 0, lat, res);
    check("c16_lat", 32'(lat), 32'd1);
    check("c16_ovf", 32'(res), 32'(pack(16'h8000, 0, 1, 0)));
    release_out();

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rs = 1'($urandom); rc = 1'($urandom);
      if (i < 4) begin
        ra = (i < 2) ? 16'h8000 : 16'h0000;
        rb = (i[0]) ? 16'h8000 : 16'hFFFF;
      end
      run_op(1, ra, rb, rs, rc, lat, res);
      check("c16_rand", 32'(res), 32'(model(ra, rb, rs, rc)));
      release_out();
    end

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rs = 1'($urandom); rc = 1'($urandom);
      run_op(0, ra, rb, rs, rc, lat, res);
      check("c4_rand", 32'(res), 32'(model(ra, rb, rs, rc)));
      release_out();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_addsub.md
Name: seq_addsub

Overview:
- Parametrised, multi-cycle adder/subtractor with a carry-chain slice of CHUNK bits. It processes one slice of a WIDTH-bit operand pair per clock.
- It extends the existing 8-bit combinational ripple adder with:
  - generic width and subtract mode,
  - correct signed overflow,
  - a zero flag,
  - a valid/ready handshake on input and output.
- Used by datapath blocks that need wide add/sub without a long combinational carry path.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be ≥ 2 and a multiple of CHUNK.
- CHUNK, 4, bits processed per clock. N = WIDTH/CHUNK slices. CHUNK = WIDTH gives a single-slice operation.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous abort; returns to IDLE
- in_valid  in  1  operand request
- in_ready  out  1  block can accept operands
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- sub  in  1  0 = add, 1 = subtract
- cin  in  1  carry-in (add) / borrow-in (sub)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- S  out  WIDTH  result
- cout  out  1  carry out of bit WIDTH-1 (sub: 1 = no borrow)
- ovfl  out  1  two's-complement signed overflow
- zero  out  1  S == 0

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE
  - in_ready = 1
  - out_valid = 0
  - S = 0, cout = 0, ovfl = 0, zero = 0
  - slice index = 0, internal carry = 0
- Arithmetic:
  - Computes A + (B XOR {WIDTH{sub}}) + (cin XOR sub).
  - sub = 1, cin = 0 gives A − B; sub = 1, cin = 1 gives A − B − 1.
  - cout = raw carry out of the MSB.
  - ovfl = carry into MSB XOR carry out of MSB.
  - zero = (S == 0).
- Operands, sub and cin are captured on acceptance. Later input changes have no effect on the operation in flight.
- States:
  - IDLE: in_ready = 1, out_valid = 0. If in_valid is high at a clock edge, capture the operands, set carry = cin XOR sub, set index = 0, go to RUN.
  - RUN: in_ready = 0. Each edge adds slice[index] of A and modified B with the stored carry, writes that slice of S, updates carry, increments index. The edge that processes slice N−1 also:
    - latches cout and ovfl,
    - computes zero from the completed S,
    - goes to DONE.
  - DONE: out_valid = 1, in_ready = 0. S, cout, ovfl and zero are held stable. If out_ready is high at an edge, go to IDLE. out_valid drops in the following cycle.
- Latency: out_valid rises exactly N clock edges after the accepting edge. Minimum initiation interval is N+2 cycles; there is no overlap between operations.
- Backpressure: DONE holds indefinitely while out_ready = 0. in_valid is ignored outside IDLE.
- clr (synchronous, highest priority after reset):
  - Any state goes to IDLE on the next edge; out_valid = 0 after that edge.
  - S and flags keep their old values; they are meaningful only while out_valid = 1.
  - clr together with in_valid in IDLE: the request is not accepted.
- Reset mid-RUN or mid-DONE: the operation is discarded and outputs return immediately to their reset values.
- S slices not yet computed during RUN are don't-care externally. Only S/cout/ovfl/zero qualified by out_valid are architectural.

Test Plan (WIDTH=16, CHUNK=4, N=4):
- A=0x7FFF, B=0x0001, sub=0, cin=0 → S=0x8000, cout=0, ovfl=1, zero=0; out_valid exactly 4 edges after acceptance.
- A=0x1234, B=0x1234, sub=1, cin=0 → S=0x0000, cout=1, ovfl=0, zero=1.
- A=0xFFFF, B=0x0001, sub=0, cin=1 → S=0x0001, cout=1, ovfl=0; then A=0x8000, B=0x0001, sub=1 → S=0x7FFF, cout=1, ovfl=1.
- Hold out_ready=0 for 6 cycles in DONE while toggling in_valid/A/B:
  - S and flags stay stable; in_ready=0;
  - after out_ready=1: one cycle in IDLE, then the next request is accepted and computed with fresh operands.
- Assert clr in the 2nd RUN cycle → IDLE next edge, out_valid never rises. Assert rst_n low mid-RUN → all outputs at reset values asynchronously; a following add 0x0003+0x0004 gives 0x0007.
- Re-parametrise CHUNK=16 → out_valid 1 edge after acceptance. Random A/B/sub/cin (1000 vectors) match the reference model for S, cout, ovfl and zero.
